exwordtx: RTL

Word-to-byte transmit serializer for the exbus debug link. Sits directly downstream of the exbus transmit FIFO, which runs in asynchronous-read mode. It pops one BW-bit word at a time, emits it MSB-byte-first on a valid/ready byte stream toward the UART transmitter, and inserts a keep-alive byte when the link has been idle too long.

---
 rtl/exwordtx.sv | 81 ++++++++
 1 files changed

// File: rtl/exwordtx.sv
`default_nettype none
// ============================================================================
// Module  : exwordtx
// Brief   : exbus word-to-byte transmit serializer with idle keep-alive byte.
// Revision: 1.0  initial release
// ============================================================================
module exwordtx #(
  parameter int          BW            = 32,
  parameter int          LGIDLE        = 20,
  parameter bit          OPT_KEEPALIVE = 1'b1,
  parameter logic [7:0]  IDLE_CHAR     = 8'hff
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_fifo_empty,
  input  logic [BW-1:0] i_fifo_data,
  output logic          o_fifo_rd,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic [7:0]    o_tx_data,
  output logic          o_busy
);

  localparam int NB = BW / 8;
  localparam int NW = $clog2(NB + 1);
  localparam logic [LGIDLE-1:0] c_idle_max = '1;
  localparam logic [NW-1:0]     c_one      = NW'(1);
  localparam logic [NW-1:0]     c_nb       = NW'(NB);

  logic [BW-1:0]     r_sreg;
  logic [NW-1:0]     r_nleft;
  logic [LGIDLE-1:0] r_idle;
  logic              w_stall;
  logic              w_avail;
  logic              w_idle_now;

  assign w_stall    = o_tx_valid && !i_tx_ready;
  // Free output register, or its final byte leaves this cycle: next word may pop.
  assign w_avail    = !w_stall && (r_nleft <= c_one);
  assign o_fifo_rd  = !i_reset && !i_fifo_empty && w_avail;
  assign o_busy     = o_tx_valid || !i_fifo_empty;
  assign w_idle_now = !o_tx_valid && i_fifo_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'h00;
      r_nleft    <= '0;
      r_sreg     <= '0;
    end else if (o_fifo_rd) begin
      o_tx_data  <= i_fifo_data[BW-1:BW-8];
      r_sreg     <= i_fifo_data << 8;
      r_nleft    <= c_nb;
      o_tx_valid <= 1'b1;
    end else if (o_tx_valid && i_tx_ready && (r_nleft > c_one)) begin
      o_tx_data  <= r_sreg[BW-1:BW-8];
      r_sreg     <= r_sreg << 8;
      r_nleft    <= r_nleft - c_one;
    end else if (o_tx_valid && i_tx_ready) begin
      o_tx_valid <= 1'b0;
      r_nleft    <= '0;
    end else if (OPT_KEEPALIVE && w_idle_now && (r_idle == c_idle_max)) begin
      o_tx_data  <= IDLE_CHAR;
      o_tx_valid <= 1'b1;
      r_nleft    <= c_one;
    end
  end

  // Saturates at c_idle_max only for the single cycle the keep-alive fires.
  always_ff @(posedge i_clk) begin
    if (i_reset || !OPT_KEEPALIVE || !w_idle_now) begin
      r_idle <= '0;
    end else if (r_idle == c_idle_max) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end

endmodule
`default_nettype wire
